// File: rtl/pipeline_pkg.sv
// Types and constants shared by the fetch and decode stages of the MIPS32 pipeline.
package pipeline_pkg;

    localparam int XLEN = 32;

    // Instruction word used for empty or flushed IF/ID slots (sll $0,$0,0)
    localparam logic [XLEN-1:0] DEFAULT_NOP = 32'h0000_0000;

    // Fetch controller states
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // IF/ID pipeline register as seen by decode
    typedef struct packed {
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] ir;
        logic            valid;
    } if_id_t;

    // One parked fetch result waiting for decode to free up
    typedef struct packed {
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] ir;
    } skid_entry_t;

    // Sequential fetch address; wraps modulo 2^32, low bits untouched
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/imem_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
interface imem_if;
    import pipeline_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register for a fetch result that decode could not take.
module fetch_skid_buf
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  skid_entry_t din,
    output skid_entry_t dout,
    output logic        full
);

    skid_entry_t entry;

    // Capture on load; clear and unload both empty the slot and take priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
            full  <= 1'b0;
        end else if (clear || unload) begin
            full  <= 1'b0;
        end else if (load) begin
            entry <= din;
            full  <= 1'b1;
        end
    end

    assign dout = entry;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory bus and
// fills the IF/ID register, honouring decode stall and execute redirects.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    imem_if.master          imem,
    output logic [XLEN-1:0] NPC_if,
    output logic [XLEN-1:0] IR_if,
    output logic            valid_if
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] pending, pending_next;
    if_id_t          if_id, if_id_next;

    logic            adv;
    logic [XLEN-1:0] pc_plus4;
    if_id_t          bubble;

    logic            skid_load;
    logic            skid_unload;
    logic            skid_clear;
    skid_entry_t     skid_din;
    skid_entry_t     skid_q;
    logic            skid_full;

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (skid_din),
        .dout   (skid_q),
        .full   (skid_full)
    );

    assign adv      = !stall || !if_id.valid;
    assign pc_plus4 = next_pc(pc);
    assign bubble   = '{npc: if_id.npc, ir: NOP_INSTR, valid: 1'b0};

    // Next-state, PC, pending-target and IF/ID selection for the fetch controller
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending;
        if_id_next   = if_id;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;
        skid_din     = '{npc: pc_plus4, ir: imem.rdata};

        case (state)
            REQ: begin
                if (imem.ack) begin
                    if (redirect) begin
                        pc_next = redirect_pc;
                    end else begin
                        pc_next = pc_plus4;
                        if (adv) begin
                            if_id_next = '{npc: pc_plus4, ir: imem.rdata, valid: 1'b1};
                        end else begin
                            skid_load  = 1'b1;
                            state_next = HOLD;
                        end
                    end
                end else if (redirect) begin
                    pending_next = redirect_pc;
                    state_next   = DROP;
                end else if (adv) begin
                    if_id_next = bubble;
                end
            end

            DROP: begin
                if (redirect) begin
                    pending_next = redirect_pc;
                end
                if (imem.ack) begin
                    pc_next    = redirect ? redirect_pc : pending;
                    state_next = REQ;
                end
                if (adv) begin
                    if_id_next = bubble;
                end
            end

            HOLD: begin
                if (redirect) begin
                    skid_clear = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (adv) begin
                    if_id_next  = '{npc: skid_q.npc, ir: skid_q.ir, valid: skid_full};
                    skid_unload = 1'b1;
                    state_next  = REQ;
                end
            end

            default: begin
                state_next = REQ;
            end
        endcase

        // A redirect squashes whatever decode would see next, even under stall
        if (redirect) begin
            if_id_next = bubble;
        end
    end

    // Fetch controller, PC and IF/ID register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= REQ;
            pc      <= RESET_PC;
            pending <= '0;
            if_id   <= '{npc: '0, ir: NOP_INSTR, valid: 1'b0};
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            pending <= pending_next;
            if_id   <= if_id_next;
        end
    end

    assign imem.req  = (state != HOLD);
    assign imem.addr = pc;

    assign NPC_if   = if_id.npc;
    assign IR_if    = if_id.ir;
    assign valid_if = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, redirects with wait
// states, redirect in HOLD, double redirect, PC wrap and async reset.
module tb_fetch_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n_hi;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] npc_main, ir_main, npc_hi, ir_hi;
    logic        valid_main, valid_hi;

    int          wait_states;
    int          wait_cnt;
    int          pass_count;
    int          check_count;

    imem_if mem();
    imem_if mem_hi();

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (mem),
        .NPC_if      (npc_main),
        .IR_if       (ir_main),
        .valid_if    (valid_main)
    );

    fetch_stage #(
        .RESET_PC  (32'hFFFF_FFF8),
        .NOP_INSTR (32'h0000_0000)
    ) dut_hi (
        .clk         (clk),
        .rst_n       (rst_n_hi),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0000_0000),
        .imem        (mem_hi),
        .NPC_if      (npc_hi),
        .IR_if       (ir_hi),
        .valid_if    (valid_hi)
    );

    // Memory for the main DUT: acknowledges after wait_states cycles of request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 0;
        else if (mem.req && !mem.ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    assign mem.ack      = mem.req && (wait_cnt == wait_states);
    assign mem.rdata    = mem.addr ^ 32'hA5A5_0000;
    assign mem_hi.ack   = mem_hi.req;
    assign mem_hi.rdata = mem_hi.addr ^ 32'hA5A5_0000;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic expect_main(input string tag, input logic req, input logic [31:0] addr,
                               input logic [31:0] npc, input logic [31:0] ir,
                               input logic valid);
        check_output({tag, ".req"},   {31'd0, mem.req},    {31'd0, req});
        check_output({tag, ".addr"},  mem.addr,            addr);
        check_output({tag, ".npc"},   npc_main,            npc);
        check_output({tag, ".ir"},    ir_main,             ir);
        check_output({tag, ".valid"}, {31'd0, valid_main}, {31'd0, valid});
    endtask

    task automatic expect_flush(input string tag, input logic [31:0] addr);
        check_output({tag, ".req"},   {31'd0, mem.req},    32'd1);
        check_output({tag, ".addr"},  mem.addr,            addr);
        check_output({tag, ".ir"},    ir_main,             32'h0000_0000);
        check_output({tag, ".valid"}, {31'd0, valid_main}, 32'd0);
    endtask

    task automatic expect_hi(input string tag, input logic [31:0] addr,
                             input logic [31:0] npc, input logic [31:0] ir,
                             input logic valid);
        check_output({tag, ".req"},   {31'd0, mem_hi.req}, 32'd1);
        check_output({tag, ".addr"},  mem_hi.addr,         addr);
        check_output({tag, ".npc"},   npc_hi,              npc);
        check_output({tag, ".ir"},    ir_hi,               ir);
        check_output({tag, ".valid"}, {31'd0, valid_hi},   {31'd0, valid});
    endtask

    // Drive the inputs for the coming rising edge, then move to the next falling edge
    task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        wait_states = 0;
        rst_n       = 1'b1;
        rst_n_hi    = 1'b1;
        #1;
        rst_n       = 1'b0;
        rst_n_hi    = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] reset and zero-wait streaming");
        expect_main("reset", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("stream0", 1'b1, 32'h4, 32'h4, 32'hA5A5_0000, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("stream1", 1'b1, 32'h8, 32'h8, 32'hA5A5_0004, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("stream2", 1'b1, 32'hC, 32'hC, 32'hA5A5_0008, 1'b1);

        $display("[TB] three-cycle stall with skid capture");
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_main("stall0", 1'b0, 32'h10, 32'hC, 32'hA5A5_0008, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_main("stall1", 1'b0, 32'h10, 32'hC, 32'hA5A5_0008, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_main("stall2", 1'b0, 32'h10, 32'hC, 32'hA5A5_0008, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("unskid", 1'b1, 32'h10, 32'h10, 32'hA5A5_000C, 1'b1);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("resume", 1'b1, 32'h14, 32'h14, 32'hA5A5_0010, 1'b1);

        $display("[TB] redirects against two-wait-state memory");
        wait_states = 2;
        apply_stimulus(1'b0, 1'b1, 32'h20);
        expect_flush("drop0", 32'h14);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("drop1", 32'h14);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("to20", 32'h20);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("wait20", 32'h20);
        apply_stimulus(1'b0, 1'b1, 32'h100);
        expect_flush("drop20", 32'h20);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("to100", 32'h100);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("wait100a", 32'h100);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("wait100b", 32'h100);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("got100", 1'b1, 32'h104, 32'h104, 32'hA5A5_0100, 1'b1);

        $display("[TB] redirect with stall while skid is full");
        wait_states = 0;
        apply_stimulus(1'b1, 1'b0, 32'h0);
        expect_main("hold104", 1'b0, 32'h108, 32'h104, 32'hA5A5_0100, 1'b1);
        apply_stimulus(1'b1, 1'b1, 32'h200);
        expect_flush("holdredir", 32'h200);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("got200", 1'b1, 32'h204, 32'h204, 32'hA5A5_0200, 1'b1);

        $display("[TB] two redirects during one wrong-path request");
        wait_states = 2;
        apply_stimulus(1'b0, 1'b1, 32'h40);
        expect_flush("redir40", 32'h204);
        apply_stimulus(1'b0, 1'b1, 32'h80);
        expect_flush("redir80", 32'h204);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("to80", 32'h80);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("wait80a", 32'h80);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_flush("wait80b", 32'h80);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        expect_main("got80", 1'b1, 32'h84, 32'h84, 32'hA5A5_0080, 1'b1);

        $display("[TB] address wrap and asynchronous reset");
        expect_hi("hi_reset", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0);
        rst_n_hi = 1'b1;
        @(negedge clk);
        expect_hi("hi_fetch0", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h5A5A_FFF8, 1'b1);
        @(negedge clk);
        expect_hi("hi_fetch1", 32'h0000_0000, 32'h0000_0000, 32'h5A5A_FFFC, 1'b1);
        @(negedge clk);
        expect_hi("hi_fetch2", 32'h0000_0004, 32'h0000_0004, 32'hA5A5_0000, 1'b1);
        #2;
        rst_n_hi = 1'b0;
        #1;
        expect_hi("hi_async", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n_hi = 1'b1;
        @(negedge clk);
        expect_hi("hi_restart", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h5A5A_FFF8, 1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
